ram_address_controller: RTL and testbench

- Upstream neighbour of the 16x8 program/data RAM; sole source of its 4-bit `address` and of its manual write strobe.
- Run mode: acts as the memory address register (MAR), loading the address from the bus.
- Manual (programming) mode:
  - takes the address from front-panel switches;
  - debounces the raw "write" push-button;
  - issues exactly one single-cycle write pulse per press, so the RAM stores `program_switches`.

---
 rtl/ram_address_controller.sv | 151 +++++++++++++++
 tb/tb_ram_address_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_address_controller.sv
// RAM address source: MAR in run mode, front-panel switches plus a debounced write button in manual mode.
// Optional macro RAM_ADDR_AUTO_INC_EN: manual address comes from a pointer that steps after each write.
module ram_address_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       manual_mode,
  input  logic       load_from_bus,
  input  logic [7:0] bus_in,
  input  logic [3:0] address_switches,
  input  logic       write_button,
  output logic [3:0] address,
  output logic       manual_write,
  output logic       busy
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    PULSE,
    HELD,
    RELEASE_DB
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [3:0]             mar_reg;
  logic [3:0]             manual_addr;
  logic                   btn_s;

  // The raw button is asynchronous to clk; only the last stage is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], write_button};
    end
  end

  assign btn_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_reg <= 4'd0;
    end else if (!manual_mode && load_from_bus) begin
      mar_reg <= bus_in[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (manual_mode && btn_s) begin
          state_next = PRESS_DB;
          cnt_next   = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PULSE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PULSE: begin
        state_next = HELD;
      end
      HELD: begin
        if (!btn_s) begin
          state_next = RELEASE_DB;
          cnt_next   = '0;
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_next = HELD;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Leaving programming mode aborts any press in progress without a write.
    if (!manual_mode) begin
      state_next = IDLE;
    end
  end

  assign manual_write = (state_reg == PULSE) && manual_mode;
  assign busy         = (state_reg != IDLE);

`ifdef RAM_ADDR_AUTO_INC_EN
  logic [3:0] ptr_reg;
  logic [3:0] sw_prev_reg;
  logic       mode_prev_reg;

  // Switch activity (or entering manual mode) reloads the pointer and beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= 4'd0;
      sw_prev_reg   <= 4'd0;
      mode_prev_reg <= 1'b0;
    end else begin
      mode_prev_reg <= manual_mode;
      sw_prev_reg   <= address_switches;
      if ((manual_mode && !mode_prev_reg) || (address_switches != sw_prev_reg)) begin
        ptr_reg <= address_switches;
      end else if (manual_write) begin
        ptr_reg <= ptr_reg + 4'd1;
      end
    end
  end

  assign manual_addr = ptr_reg;
`else
  assign manual_addr = address_switches;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address <= 4'd0;
    end else begin
      address <= manual_mode ? manual_addr : mar_reg;
    end
  end

endmodule

// File: tb/tb_ram_address_controller.sv
// Directed bench for ram_address_controller: MAR path, button debounce, mode abort, async reset.
module tb_ram_address_controller;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       manual_mode = 1'b0;
  logic       load_from_bus = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic [3:0] address_switches = 4'h0;
  logic       write_button = 1'b0;
  logic [3:0] address;
  logic       manual_write;
  logic       busy;

  int         n_vec = 0;
  int         n_bad = 0;
  int         pulse_count = 0;
  int         run_wr_count = 0;
  logic [3:0] pulse_addr [16];
  int         p0;

  always #5 clk = ~clk;

  ram_address_controller #(
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES    (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .manual_mode     (manual_mode),
    .load_from_bus   (load_from_bus),
    .bus_in          (bus_in),
    .address_switches(address_switches),
    .write_button    (write_button),
    .address         (address),
    .manual_write    (manual_write),
    .busy            (busy)
  );

  // Record every write strobe together with the address it was issued at.
  always @(negedge clk) begin
    if (manual_write) begin
      pulse_addr[4'(pulse_count)] <= address;
      pulse_count <= pulse_count + 1;
      if (!manual_mode) run_wr_count <= run_wr_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    write_button = 1'b1;
    tick(hi);
    write_button = 1'b0;
    tick(lo);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_address", 32'(address), 0);
    check_eq("rst_write", 32'(manual_write), 0);
    check_eq("rst_busy", 32'(busy), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // MAR load from bus, upper nibble ignored
    manual_mode   = 1'b0;
    bus_in        = 8'hA7;
    load_from_bus = 1'b1;
    tick(1);
    load_from_bus = 1'b0;
    bus_in        = 8'h3C;
    check_eq("mar_latency", 32'(address), 0);
    tick(1);
    check_eq("mar_load", 32'(address), 7);
    bus_in = 8'hF2;
    tick(3);
    check_eq("mar_hold", 32'(address), 7);

    // Manual mode: load strobe ignored, address follows switches
    manual_mode      = 1'b1;
    address_switches = 4'h3;
    bus_in           = 8'h05;
    load_from_bus    = 1'b1;
    tick(1);
    load_from_bus = 1'b0;
    tick(1);
    check_eq("manual_addr", 32'(address), 3);

    // Bouncy press, long hold, bouncy release -> one pulse
    p0 = pulse_count;
    write_button = 1'b1; tick(1);
    write_button = 1'b0; tick(1);
    write_button = 1'b1; tick(30);
    check_eq("busy_held", 32'(busy), 1);
    write_button = 1'b0; tick(1);
    write_button = 1'b1; tick(1);
    write_button = 1'b0; tick(20);
    check_eq("bounce_pulses", 32'(pulse_count - p0), 1);
    check_eq("bounce_addr", 32'(pulse_addr[4'(p0)]), 3);
    check_eq("bounce_idle", 32'(busy), 0);

    manual_mode = 1'b0;
    tick(1);
    check_eq("mar_kept", 32'(address), 7);

    // Short presses rejected; 4 high cycles too short, 5 just enough
    manual_mode = 1'b1;
    tick(2);
    p0 = pulse_count;
    repeat (4) press(2, 3);
    tick(10);
    check_eq("short_pulses", 32'(pulse_count - p0), 0);
    check_eq("short_idle", 32'(busy), 0);
    press(4, 12);
    check_eq("press4_pulses", 32'(pulse_count - p0), 0);
    press(5, 12);
    check_eq("press5_pulses", 32'(pulse_count - p0), 1);
    check_eq("press5_idle", 32'(busy), 0);
    manual_mode = 1'b0;
    tick(2);

    // Mode dropped during PRESS_DB
    manual_mode      = 1'b1;
    address_switches = 4'h3;
    tick(3);
    check_eq("drop_addr_manual", 32'(address), 3);
    p0 = pulse_count;
    write_button = 1'b1;
    tick(4);
    check_eq("busy_press_db", 32'(busy), 1);
    manual_mode = 1'b0;
    check_eq("addr_before_drop", 32'(address), 3);
    tick(1);
    check_eq("drop_idle", 32'(busy), 0);
    check_eq("drop_addr_mar", 32'(address), 7);
    tick(10);
    check_eq("drop_pulses", 32'(pulse_count - p0), 0);
    write_button = 1'b0;
    tick(5);

    // Async reset while HELD with mar=9
    bus_in        = 8'h09;
    load_from_bus = 1'b1;
    tick(1);
    load_from_bus    = 1'b0;
    manual_mode      = 1'b1;
    address_switches = 4'h3;
    write_button     = 1'b1;
    tick(12);
    check_eq("pre_rst_busy", 32'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_addr", 32'(address), 0);
    check_eq("async_rst_busy", 32'(busy), 0);
    check_eq("async_rst_write", 32'(manual_write), 0);
    manual_mode  = 1'b0;
    write_button = 1'b0;
    #10;
    rst_n = 1'b1;
    tick(2);
    check_eq("post_rst_addr", 32'(address), 0);
    check_eq("post_rst_busy", 32'(busy), 0);

`ifdef RAM_ADDR_AUTO_INC_EN
    // Pointer auto-increment across presses, wrap, then switch reload
    manual_mode      = 1'b1;
    address_switches = 4'hE;
    tick(3);
    p0 = pulse_count;
    repeat (3) press(8, 12);
    address_switches = 4'h5;
    tick(3);
    press(8, 12);
    check_eq("inc_pulses", 32'(pulse_count - p0), 4);
    check_eq("inc_addr0", 32'(pulse_addr[4'(p0)]), 32'hE);
    check_eq("inc_addr1", 32'(pulse_addr[4'(p0 + 1)]), 32'hF);
    check_eq("inc_addr2", 32'(pulse_addr[4'(p0 + 2)]), 32'h0);
    check_eq("inc_reload", 32'(pulse_addr[4'(p0 + 3)]), 32'h5);
    manual_mode = 1'b0;
    tick(2);
`endif

    check_eq("no_write_in_run", 32'(run_wr_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
